// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and byte-lane helper for the MEM-stage load/store engine.
package mem_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Little-endian byte-lane enables; the reserved size 11 behaves as a word.
  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << addr_lo;
      SZ_HALF: m = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load-data aligner: picks the addressed byte/halfword lane and sign- or zero-extends it.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        extr_signed,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection followed by extension; word (and reserved size) passes straight through.
  always_comb begin
    byte_sel = rdata[8*addr_lo +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: result = {{24{extr_signed & byte_sel[7]}}, byte_sel};
      SZ_HALF: result = {{16{extr_signed & half_sel[15]}}, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: issues one req/ack transaction per memory op,
// stalls the pipeline while it is outstanding, and aborts via a watchdog.
//
// state | meaning
// IDLE  | waiting for an aligned memory op; non-memory and misaligned ops pass through
// REQ   | request outstanding, bus outputs held, watchdog counting
// DONE  | transaction finished (ack or abort); pipeline advances for one cycle
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_BITS      = 32,
  parameter int ADDR_BITS      = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_BITS       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 op_valid,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic [1:0]           size,
  input  logic                 ExtrSigned,
  input  logic [ADDR_BITS-1:0] alu_out,
  input  logic [DATA_BITS-1:0] store_data,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [3:0]           mem_wmask,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic                 mem_ack,
  input  logic [DATA_BITS-1:0] mem_rdata,
  output logic [DATA_BITS-1:0] mem_out,
  output logic                 mem_ready,
  output logic                 addr_err,
  output logic                 bus_err
);

  state_t               state, state_nxt;
  logic [CNT_BITS-1:0]  cnt;
  logic                 access, misaligned;
  logic                 start, complete, abort;
  logic [DATA_BITS-1:0] wdata_rep;
  logic [DATA_BITS-1:0] load_val;

  assign access = op_valid & (MemRead | MemWrite);

  // Alignment check and store-lane replication from the presented op.
  always_comb begin
    case (size)
      SZ_BYTE: begin
        misaligned = 1'b0;
        wdata_rep  = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        misaligned = alu_out[0];
        wdata_rep  = {2{store_data[15:0]}};
      end
      default: begin
        misaligned = |alu_out[1:0];
        wdata_rep  = store_data;
      end
    endcase
  end

  mem_load_align u_align (
    .rdata       (mem_rdata),
    .addr_lo     (alu_out[1:0]),
    .size        (size),
    .extr_signed (ExtrSigned),
    .result      (load_val)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, stall and error outputs; ack wins over the watchdog in the same cycle.
  always_comb begin
    state_nxt = state;
    mem_ready = 1'b1;
    addr_err  = 1'b0;
    start     = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (misaligned) begin
            addr_err = 1'b1;
          end else begin
            mem_ready = 1'b0;
            start     = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        mem_ready = 1'b0;
        if (mem_ack) begin
          complete  = 1'b1;
          state_nxt = DONE;
        end else if (cnt == CNT_BITS'(TIMEOUT_CYCLES - 1)) begin
          abort     = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus outputs, load result, watchdog counter and abort pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wmask <= '0;
      mem_wdata <= '0;
      mem_out   <= '0;
      bus_err   <= 1'b0;
      cnt       <= '0;
    end else begin
      bus_err <= abort;
      if (start) begin
        mem_req   <= 1'b1;
        mem_we    <= MemWrite;
        mem_addr  <= {alu_out[ADDR_BITS-1:2], 2'b00};
        mem_wmask <= MemWrite ? byte_mask(size, alu_out[1:0]) : 4'b0000;
        mem_wdata <= wdata_rep;
        cnt       <= '0;
      end else if (complete) begin
        mem_req <= 1'b0;
        if (!mem_we) mem_out <= load_val;
      end else if (abort) begin
        mem_req <= 1'b0;
        mem_out <= '0;
      end else if (state == REQ) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a short watchdog (TIMEOUT_CYCLES=4).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid, MemRead, MemWrite, ExtrSigned;
  logic [1:0]  size;
  logic [31:0] alu_out, store_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata, mem_out;
  logic        mem_ready, addr_err, bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sb_q[$];

  mem_access_unit #(
    .DATA_BITS(32), .ADDR_BITS(32), .TIMEOUT_CYCLES(4), .CNT_BITS(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .MemRead(MemRead), .MemWrite(MemWrite),
    .size(size), .ExtrSigned(ExtrSigned), .alu_out(alu_out), .store_data(store_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_out(mem_out),
    .mem_ready(mem_ready), .addr_err(addr_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld, rd, wr;
    logic [1:0]  sz;
    logic        sgn;
    logic [31:0] addr, sdata, rdata;
    int          ack_dly;   // REQ cycles without ack before ack; -1 = never
    logic        aerr;
    logic [3:0]  mask;
    logic [31:0] wdata, out;
    int          stall;
    logic        berr;
  } vec_t;

  function automatic vec_t mk(logic vld, logic rd, logic wr, logic [1:0] sz, logic sgn,
                              logic [31:0] addr, logic [31:0] sdata, logic [31:0] rdata,
                              int ack_dly, logic aerr, logic [3:0] mask, logic [31:0] wdata,
                              logic [31:0] out, int stall, logic berr);
    vec_t v;
    v.vld = vld; v.rd = rd; v.wr = wr; v.sz = sz; v.sgn = sgn;
    v.addr = addr; v.sdata = sdata; v.rdata = rdata; v.ack_dly = ack_dly;
    v.aerr = aerr; v.mask = mask; v.wdata = wdata; v.out = out; v.stall = stall; v.berr = berr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Present one op, play the memory side, and check bus fields, stall length and result.
  task automatic run_vec(input vec_t v, input bit from_done, input bit keep);
    int  stall, waits;
    bit  first, done;
    logic [31:0] exp_out;
    op_valid = v.vld; MemRead = v.rd; MemWrite = v.wr; size = v.sz;
    ExtrSigned = v.sgn; alu_out = v.addr; store_data = v.sdata; mem_ack = 1'b0;
    if (from_done) @(negedge clk);
    #1;
    chk("addr_err", addr_err, v.aerr);
    sb_q.push_back(v.out);
    stall = 0; waits = 0; first = 1'b1; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (mem_ready) begin
        done = 1'b1;
      end else begin
        stall++;
        if (mem_req) begin
          if (first) begin
            chk("mem_addr", mem_addr, v.addr & 32'hFFFF_FFFC);
            chk("mem_we", mem_we, v.wr);
            if (v.wr) begin
              chk("mem_wmask", mem_wmask, v.mask);
              chk("mem_wdata", mem_wdata, v.wdata);
            end
            first = 1'b0;
          end
          mem_ack   = (waits == v.ack_dly);
          mem_rdata = v.rdata;
          waits++;
        end
        @(negedge clk); #1;
      end
    end
    mem_ack = 1'b0;
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL wait_ready: got no mem_ready within 40 cycles, want ready");
    end
    chk("stall_cycles", 32'(stall), 32'(v.stall));
    chk("bus_err_done", bus_err, v.berr);
    chk("mem_req_done", mem_req, 1'b0);
    exp_out = sb_q.pop_front();
    chk("mem_out", mem_out, exp_out);
    if (!keep) begin
      op_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
      @(negedge clk); #1;
      chk("mem_req_idle", mem_req, 1'b0);
      chk("bus_err_idle", bus_err, 1'b0);
    end
  endtask

  localparam logic [1:0] W = 2'b00, B = 2'b01, H = 2'b10, R = 2'b11;

  vec_t vecs[18];

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst_n = 1'b0; op_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; size = 2'b00;
    ExtrSigned = 1'b0; alu_out = '0; store_data = '0; mem_ack = 1'b0; mem_rdata = '0;

    vecs[0]  = mk(1,1,0,W,0,32'h100,32'h0,32'hDEADBEEF, 0,0,4'h0,32'h0,32'hDEADBEEF,2,0);
    vecs[1]  = mk(1,1,0,B,1,32'h103,32'h0,32'h80112233, 0,0,4'h0,32'h0,32'hFFFFFF80,2,0);
    vecs[2]  = mk(1,1,0,B,0,32'h103,32'h0,32'h80112233, 0,0,4'h0,32'h0,32'h00000080,2,0);
    vecs[3]  = mk(1,0,1,H,0,32'h202,32'h0000ABCD,32'h0, 3,0,4'hC,32'hABCDABCD,32'h00000080,5,0);
    vecs[4]  = mk(1,1,0,H,1,32'h102,32'h0,32'h80F11234, 1,0,4'h0,32'h0,32'hFFFF80F1,3,0);
    vecs[5]  = mk(1,1,0,H,0,32'h100,32'h0,32'h1234F00D, 0,0,4'h0,32'h0,32'h0000F00D,2,0);
    vecs[6]  = mk(1,0,1,B,0,32'h101,32'h12345678,32'h0, 0,0,4'h2,32'h78787878,32'h0000F00D,2,0);
    vecs[7]  = mk(1,0,1,W,0,32'h300,32'hCAFEF00D,32'h0, 2,0,4'hF,32'hCAFEF00D,32'h0000F00D,4,0);
    vecs[8]  = mk(1,1,0,B,1,32'h101,32'h0,32'h11227F44, 0,0,4'h0,32'h0,32'h0000007F,2,0);
    vecs[9]  = mk(1,1,0,W,0,32'h400,32'h0,32'h0,       -1,0,4'h0,32'h0,32'h00000000,5,1);
    vecs[10] = mk(1,1,0,W,0,32'h101,32'h0,32'h0,        0,1,4'h0,32'h0,32'h00000000,0,0);
    vecs[11] = mk(1,0,1,H,0,32'h203,32'h0000FFFF,32'h0, 0,1,4'h0,32'h0,32'h00000000,0,0);
    vecs[12] = mk(1,1,0,B,1,32'h102,32'h0,32'h00800000, 0,0,4'h0,32'h0,32'hFFFFFF80,2,0);
    vecs[13] = mk(1,0,0,W,0,32'h100,32'h0,32'h0,        0,0,4'h0,32'h0,32'hFFFFFF80,0,0);
    vecs[14] = mk(1,1,0,R,0,32'h104,32'h0,32'h01020304, 0,0,4'h0,32'h0,32'h01020304,2,0);
    vecs[15] = mk(1,1,0,H,1,32'h105,32'h0,32'h0,        0,1,4'h0,32'h0,32'h01020304,0,0);
    vecs[16] = mk(1,1,0,B,0,32'h107,32'h0,32'hA1B2C3D4, 1,0,4'h0,32'h0,32'h000000A1,3,0);
    vecs[17] = mk(0,1,0,W,0,32'h101,32'h0,32'h0,        0,0,4'h0,32'h0,32'h000000A1,0,0);

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wmask", mem_wmask, 4'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_out", mem_out, 32'h0);
    chk("rst_bus_err", bus_err, 1'b0);
    chk("rst_mem_ready", mem_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk); #1;

    for (int i = 0; i < 18; i++) run_vec(vecs[i], 1'b0, 1'b0);

    // Ack while idle must be ignored
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    #1;
    chk("stray_ack_req", mem_req, 1'b0);
    chk("stray_ack_out", mem_out, 32'h000000A1);
    chk("stray_ack_berr", bus_err, 1'b0);
    mem_ack = 1'b0;
    @(negedge clk); #1;

    // Back-to-back: second op presented during DONE starts normally from IDLE
    run_vec(mk(1,1,0,W,0,32'h600,32'h0,32'h11111111,0,0,4'h0,32'h0,32'h11111111,2,0), 1'b0, 1'b1);
    run_vec(mk(1,1,0,H,0,32'h602,32'h0,32'h22223333,0,0,4'h0,32'h0,32'h00002222,2,0), 1'b1, 1'b0);

    // Reset mid-REQ drops the request asynchronously
    op_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; size = W; ExtrSigned = 1'b0;
    alu_out = 32'h500; mem_ack = 1'b0;
    @(negedge clk); #1;
    chk("req_before_rst", mem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("req_async_rst", mem_req, 1'b0);
    chk("out_async_rst", mem_out, 32'h0);
    op_valid = 1'b0; MemRead = 1'b0;
    #1;
    chk("ready_in_rst", mem_ready, 1'b1);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    run_vec(mk(1,1,0,B,0,32'h106,32'h0,32'h00AB0000,0,0,4'h0,32'h0,32'h000000AB,2,0), 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
